// File: rtl/rr_arb_pipe.sv
// N-input round-robin arbiter feeding one registered valid/data/enable stage.
// Optional packet lock (whole packets per grant) is enabled by RR_ARB_PKT_LOCK_EN.
module rr_arb_pipe #(
  parameter int N  = 4,
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         v_up,
  input  logic [N*DW-1:0]      d_up,
  output logic [N-1:0]         e_up,
  output logic                 v_down,
  output logic [DW-1:0]        d_down,
  output logic [$clog2(N)-1:0] id_down,
  input  logic                 e_down
`ifdef RR_ARB_PKT_LOCK_EN
  ,
  input  logic [N-1:0]         l_up,
  output logic                 l_down
`endif
);
  localparam int IW = $clog2(N);

  logic [N-1:0][DW-1:0] d_arr;
  logic [IW-1:0]        ptr, g_rr, g, ptr_nxt;
  logic [IW:0]          s;
  logic [N-1:0]         gnt;
  logic                 found, any_gnt, e_l, acc, ptr_upd;

  assign d_arr = d_up;
  assign e_l   = e_down | ~v_down;

  // Walk priority order ptr, ptr+1, ... with an extra bit so non-power-of-two N wraps correctly.
  always_comb begin
    found = 1'b0;
    g_rr  = '0;
    s     = '0;
    for (int k = 0; k < N; k++) begin
      s = {1'b0, ptr} + (IW+1)'(k);
      if (s >= (IW+1)'(N)) s = s - (IW+1)'(N);
      if (!found && v_up[s[IW-1:0]]) begin
        found = 1'b1;
        g_rr  = s[IW-1:0];
      end
    end
  end

`ifdef RR_ARB_PKT_LOCK_EN
  logic          lock;
  logic [IW-1:0] lock_id;

  // A locked packet owns the stage; a gap from its owner is a bubble, not a hand-off.
  always_comb begin
    g       = g_rr;
    any_gnt = found;
    if (lock) begin
      g       = lock_id;
      any_gnt = v_up[lock_id];
    end
  end

  assign ptr_upd = l_up[g];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock    <= 1'b0;
      lock_id <= '0;
      l_down  <= 1'b0;
    end else if (acc) begin
      lock    <= ~l_up[g];
      lock_id <= g;
      l_down  <= l_up[g];
    end
  end
`else
  assign g       = g_rr;
  assign any_gnt = found;
  assign ptr_upd = 1'b1;
`endif

  always_comb begin
    gnt    = '0;
    gnt[g] = any_gnt;
  end

  assign e_up    = gnt & {N{e_l}};
  assign acc     = e_l & any_gnt;
  assign ptr_nxt = (g == IW'(N-1)) ? '0 : g + IW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_down  <= 1'b0;
      d_down  <= '0;
      id_down <= '0;
      ptr     <= '0;
    end else if (e_l) begin
      v_down <= any_gnt;
      if (acc) begin
        d_down  <= d_arr[g];
        id_down <= g;
        if (ptr_upd) ptr <= ptr_nxt;
      end
    end
  end
endmodule

// File: tb/tb_rr_arb_pipe.sv
// Directed bench for rr_arb_pipe: table of per-cycle vectors for N=4, plus
// hand-written reset, N=3 wrap and (when RR_ARB_PKT_LOCK_EN) packet-lock sequences.
module tb_rr_arb_pipe;
  localparam logic [31:0] BASE = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  v_up, e_up;
  logic [127:0] d_up;
  logic        v_down, e_down;
  logic [31:0] d_down;
  logic [1:0]  id_down;

  logic [2:0]  v_up3, e_up3;
  logic [95:0] d_up3;
  logic        v_down3, e_down3;
  logic [31:0] d_down3;
  logic [1:0]  id_down3;

`ifdef RR_ARB_PKT_LOCK_EN
  logic [3:0] l_up;
  logic       l_down;
  logic [2:0] l_up3;
  logic       l_down3;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  rr_arb_pipe #(.N(4), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .v_up(v_up), .d_up(d_up), .e_up(e_up),
    .v_down(v_down), .d_down(d_down), .id_down(id_down), .e_down(e_down)
`ifdef RR_ARB_PKT_LOCK_EN
    , .l_up(l_up), .l_down(l_down)
`endif
  );

  rr_arb_pipe #(.N(3), .DW(32)) dut3 (
    .clk(clk), .rst_n(rst_n), .v_up(v_up3), .d_up(d_up3), .e_up(e_up3),
    .v_down(v_down3), .d_down(d_down3), .id_down(id_down3), .e_down(e_down3)
`ifdef RR_ARB_PKT_LOCK_EN
    , .l_up(l_up3), .l_down(l_down3)
`endif
  );

  typedef struct {
    logic [3:0] v;
    logic       ed;
    logic [3:0] eu;
    logic       vd;
    logic [1:0] id;
    logic [1:0] ptr;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic [3:0] v, logic ed, logic [3:0] eu, logic vd,
                              logic [1:0] id, logic [1:0] ptr);
    vec_t r;
    r.v = v; r.ed = ed; r.eu = eu; r.vd = vd; r.id = id; r.ptr = ptr;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; v_up = '0; e_down = 1'b0; v_up3 = '0; e_down3 = 1'b0;
    for (int i = 0; i < 4; i++) d_up[i*32 +: 32] = BASE | 32'(i);
    for (int i = 0; i < 3; i++) d_up3[i*32 +: 32] = BASE | 32'(i);
`ifdef RR_ARB_PKT_LOCK_EN
    l_up = '1; l_up3 = '1;
`endif

    // rotation with all valid, then backpressure, sparse, idle, stall and empty-accept cases
    for (int i = 0; i < 8; i++)
      tv.push_back(mk(4'b1111, 1'b1, 4'(1 << (i % 4)), 1'b1, 2'(i % 4), 2'((i + 1) % 4)));
    tv.push_back(mk(4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd2));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(4'b0101, 1'b0, 4'b0000, 1'b1, 2'd1, 2'd2));
    tv.push_back(mk(4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 2'd3));
    tv.push_back(mk(4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd2));
    tv.push_back(mk(4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 2'd1));
    tv.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 2'd1));
    tv.push_back(mk(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd1));
    tv.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 2'd1));
    tv.push_back(mk(4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 2'd0));
    tv.push_back(mk(4'b0011, 1'b0, 4'b0000, 1'b1, 2'd3, 2'd0));
    tv.push_back(mk(4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 2'd1));

    #1;
    chk("reset v_down", 32'(v_down), 32'd0);
    chk("reset id_down", 32'(id_down), 32'd0);
    chk("reset d_down", d_down, 32'd0);
    chk("reset ptr", 32'(dut.ptr), 32'd0);
    tick(); tick();
    rst_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      v_up = tv[i].v; e_down = tv[i].ed;
      #1;
      chk($sformatf("vec%0d e_up", i), 32'(e_up), 32'(tv[i].eu));
      tick();
      chk($sformatf("vec%0d v_down", i), 32'(v_down), 32'(tv[i].vd));
      chk($sformatf("vec%0d id_down", i), 32'(id_down), 32'(tv[i].id));
      chk($sformatf("vec%0d d_down", i), d_down, BASE | 32'(tv[i].id));
      chk($sformatf("vec%0d ptr", i), 32'(dut.ptr), 32'(tv[i].ptr));
    end

    // asynchronous reset while a beat is held
    v_up = 4'b0100; e_down = 1'b1;
    tick();
    chk("pre-reset id_down", 32'(id_down), 32'd2);
    v_up = 4'b1000; e_down = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async reset v_down", 32'(v_down), 32'd0);
    chk("async reset id_down", 32'(id_down), 32'd0);
    chk("async reset d_down", d_down, 32'd0);
    chk("async reset ptr", 32'(dut.ptr), 32'd0);
    chk("reset e_up", 32'(e_up), 32'b1000);
    #1 rst_n = 1'b1;
    e_down = 1'b1;
    #1;
    chk("post-reset e_up", 32'(e_up), 32'b1000);
    tick();
    chk("post-reset v_down", 32'(v_down), 32'd1);
    chk("post-reset id_down", 32'(id_down), 32'd3);
    chk("post-reset d_down", d_down, BASE | 32'd3);
    v_up = '0;

    // N=3: 0 and 2 alternate, pointer wraps from 2 back to 0
    v_up3 = 3'b101; e_down3 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("n3 c%0d e_up", i), 32'(e_up3), (i % 2 == 0) ? 32'b001 : 32'b100);
      tick();
      chk($sformatf("n3 c%0d id_down", i), 32'(id_down3), (i % 2 == 0) ? 32'd0 : 32'd2);
      chk($sformatf("n3 c%0d v_down", i), 32'(v_down3), 32'd1);
      chk($sformatf("n3 c%0d ptr", i), 32'(dut3.ptr), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    v_up3 = 3'b100;
    #1;
    chk("n3 lone2 e_up", 32'(e_up3), 32'b100);
    tick();
    chk("n3 lone2 ptr", 32'(dut3.ptr), 32'd0);
    v_up3 = '0;

`ifdef RR_ARB_PKT_LOCK_EN
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    begin
      logic [3:0] lv[6], ll[6], leu[6];
      logic       lvd[6], lld[6];
      logic [1:0] lid[6], lp[6];
      lv  = '{4'b0001, 4'b0111, 4'b0101, 4'b0111, 4'b0111, 4'b0111};
      ll  = '{4'b1111, 4'b1101, 4'b1101, 4'b1101, 4'b1111, 4'b1111};
      leu = '{4'b0001, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0100};
      lvd = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      lid = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
      lld = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      lp  = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};
      e_down = 1'b1;
      for (int i = 0; i < 6; i++) begin
        v_up = lv[i]; l_up = ll[i];
        #1;
        chk($sformatf("lock c%0d e_up", i), 32'(e_up), 32'(leu[i]));
        tick();
        chk($sformatf("lock c%0d v_down", i), 32'(v_down), 32'(lvd[i]));
        chk($sformatf("lock c%0d id_down", i), 32'(id_down), 32'(lid[i]));
        chk($sformatf("lock c%0d l_down", i), 32'(l_down), 32'(lld[i]));
        chk($sformatf("lock c%0d ptr", i), 32'(dut.ptr), 32'(lp[i]));
      end
      v_up = '0; l_up = '1;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
